// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter/sequencer for a shared combinational ALU
// Round-robin by default; define ALU_ARB_FIXED_PRI_EN for fixed priority (requester 0 wins ties).
module alu_arbiter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [2:0]        req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [2:0]        req1_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_result,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              gnt_q;
    logic              gnt_sel;
    logic              any_req;
    logic              rsp_ready_sel;
    logic [DATA_W-1:0] result_q;

    assign any_req       = req0_valid | req1_valid;
    assign rsp_ready_sel = gnt_q ? rsp1_ready : rsp0_ready;

`ifdef ALU_ARB_FIXED_PRI_EN
    assign gnt_sel = ~req0_valid;
`else
    logic last_grant;

    // On a tie the requester that was not served last wins.
    assign gnt_sel = (req0_valid && req1_valid) ? ~last_grant : ~req0_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (state == RESP && rsp_ready_sel) begin
            last_grant <= gnt_q;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready_sel) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        busy       = (state != IDLE);
        if (state == IDLE && any_req) begin
            req0_ready = ~gnt_sel;
            req1_ready = gnt_sel;
        end
        if (state == RESP) begin
            rsp0_valid = ~gnt_q;
            rsp1_valid = gnt_q;
        end
    end

    // ALU operands only change on an accept, so they hold through EXEC and RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= 3'b000;
            gnt_q      <= 1'b0;
            result_q   <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                alu_a      <= gnt_sel ? req1_a  : req0_a;
                alu_b      <= gnt_sel ? req1_b  : req0_b;
                alu_opcode <= gnt_sel ? req1_op : req0_op;
                gnt_q      <= gnt_sel;
            end
            if (state == EXEC) begin
                result_q <= alu_result;
            end
        end
    end

    assign rsp0_result = result_q;
    assign rsp1_result = result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with random and directed traffic
// Honours ALU_ARB_FIXED_PRI_EN to select the expected arbitration rule.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_op, req1_op;
    logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [7:0] rsp0_result, rsp1_result;
    logic [7:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_opcode;
    logic       busy;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit rnd_en = 0;
    bit model_last = 1;
    bit acc0, acc1;

    typedef struct {
        bit         id;
        logic [7:0] res;
        int         acc;
    } exp_t;
    exp_t q[$];

    alu_arbiter #(.DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return ~a;
            default: return 8'h00;
        endcase
    endfunction

    // Stand-in for the shared combinational ALU.
    assign alu_result = alu_ref(alu_a, alu_b, alu_opcode);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Arbitration model: predicts the grant and pushes the expected response.
    always @(posedge clk) begin
        int e;
        #3;
        if (rst_n) begin
            e = -1;
            chk("busy", busy, q.size() != 0);
            if (q.size() == 0) begin
                if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRI_EN
                    e = 0;
`else
                    e = model_last ? 0 : 1;
`endif
                end else if (req0_valid) e = 0;
                else if (req1_valid) e = 1;
            end
            chk("req0_ready", req0_ready, e == 0);
            chk("req1_ready", req1_ready, e == 1);
            if (e == 0) q.push_back('{1'b0, alu_ref(req0_a, req0_b, req0_op), cyc});
            if (e == 1) q.push_back('{1'b1, alu_ref(req1_a, req1_b, req1_op), cyc});
        end
    end

    // Response monitor: pops and compares whenever a response is presented.
    always @(negedge clk) begin
        exp_t e;
        bit   due;
        if (rst_n) begin
            if (q.size() == 0) begin
                chk("rsp0_valid_idle", rsp0_valid, 0);
                chk("rsp1_valid_idle", rsp1_valid, 0);
            end else begin
                e   = q[0];
                due = (cyc >= e.acc + 2);
                chk("rsp0_valid", rsp0_valid, due && e.id == 0);
                chk("rsp1_valid", rsp1_valid, due && e.id == 1);
                if (due) begin
                    chk("rsp_result", e.id ? rsp1_result : rsp0_result, e.res);
                    if (e.id ? rsp1_ready : rsp0_ready) begin
                        void'(q.pop_front());
                        model_last = e.id;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        acc0 = req0_valid && req0_ready;
        acc1 = req1_valid && req1_ready;
    end

    // Random requesters: hold payload until accepted, random response backpressure.
    always @(posedge clk) begin
        #1;
        if (rnd_en) begin
            if (acc0) req0_valid = 0;
            if (acc1) req1_valid = 0;
            if (!req0_valid && $urandom_range(0, 2) == 0) begin
                req0_valid = 1;
                req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 3'($urandom);
            end
            if (!req1_valid && $urandom_range(0, 2) == 0) begin
                req1_valid = 1;
                req1_a = 8'($urandom); req1_b = 8'($urandom); req1_op = 3'($urandom);
            end
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic reset_checks(input string tag);
        chk({tag, "_req_ready"}, {req0_ready, req1_ready}, 0);
        chk({tag, "_rsp_valid"}, {rsp0_valid, rsp1_valid}, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rsp_result"}, {rsp0_result, rsp1_result}, 0);
        chk({tag, "_alu_in"}, {alu_a, alu_b, 5'b0, alu_opcode}, 0);
    endtask

    task automatic drain();
        @(negedge clk);
        rnd_en = 0;
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic do_op(input bit id, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input logic [7:0] expv, input string name);
        bit ok;
        if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; end
        else    begin req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; end
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = id ? req1_ready : req0_ready;
        end
        chk({name, "_accept"}, ok, 1);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = id ? rsp1_valid : rsp0_valid;
        end
        chk({name, "_rsp_seen"}, ok, 1);
        chk({name, "_result"}, id ? rsp1_result : rsp0_result, expv);
        @(posedge clk); #1;
    endtask

    initial begin
        int  last;
        int  nacc;
        int  prev_g;
        bit  ok;
        rst_n = 0;
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
        #3;
        reset_checks("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        rsp0_ready = 1; rsp1_ready = 1;
        @(posedge clk); #1;

        do_op(0, 8'h0A, 8'h05, 3'b000, 8'h0F, "add_basic");
        do_op(1, 8'hFF, 8'hFF, 3'b110, 8'h00, "op110");
        do_op(0, 8'hFF, 8'hFF, 3'b000, 8'hFE, "add_wrap");
        do_op(1, 8'h05, 8'h0A, 3'b001, 8'hFB, "sub_wrap");

        // Both requesters hold valid continuously.
        req0_valid = 1; req0_a = 8'h0A; req0_b = 8'h05; req0_op = 3'b001;
        req1_valid = 1; req1_a = 8'h0A; req1_b = 8'h00; req1_op = 3'b100;
        prev_g = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp0_valid) chk("alt_rsp0_result", rsp0_result, 8'h05);
            if (rsp1_valid) chk("alt_rsp1_result", rsp1_result, 8'hF5);
            if (req0_ready || req1_ready) begin
`ifdef ALU_ARB_FIXED_PRI_EN
                chk("fixed_grant", req1_ready, 0);
`else
                if (prev_g >= 0) chk("alt_grant", req1_ready, prev_g == 0);
`endif
                prev_g = req1_ready ? 1 : 0;
            end
        end
        drain();

        // Response backpressure on requester 1.
        rsp1_ready = 0;
        req1_valid = 1; req1_a = 8'hF0; req1_b = 8'h3C; req1_op = 3'b010;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = req1_ready; end
        chk("bp_accept", ok, 1);
        @(posedge clk); #1 req1_valid = 0;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = rsp1_valid; end
        chk("bp_rsp_seen", ok, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_result", rsp1_result, 8'h30);
            chk("bp_busy", busy, 1);
            chk("bp_hold_valid", rsp1_valid, 1);
        end
        @(posedge clk); #1 rsp1_ready = 1;
        @(negedge clk);
        chk("bp_final_valid", rsp1_valid, 1);
        @(negedge clk);
        chk("bp_done_busy", busy, 0);

        // Back-to-back requester 0 with responses always taken.
        @(posedge clk); #1;
        req0_valid = 1; req0_a = 8'h11; req0_b = 8'h22; req0_op = 3'b011;
        last = -1; nacc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req0_valid && req0_ready) begin
                if (last >= 0) chk("accept_spacing", cyc - last, 3);
                last = cyc; nacc++;
            end
        end
        chk("accept_count", nacc >= 6, 1);
        drain();

        // Random traffic.
        rnd_en = 1;
        repeat (1000) @(posedge clk);
        drain();

        // Reset during EXEC.
        req0_valid = 1; req0_a = 8'h33; req0_b = 8'h44; req0_op = 3'b000;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = req0_ready; end
        chk("rst_accept", ok, 1);
        @(posedge clk); #1;
        req0_valid = 0;
        rst_n = 0;
        q.delete();
        model_last = 1;
        #1 reset_checks("mid_reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        repeat (4) @(posedge clk);
        #1;
        req0_valid = 1; req1_valid = 1;
        req0_a = 8'h01; req0_b = 8'h02; req0_op = 3'b000;
        req1_a = 8'h03; req1_b = 8'h04; req1_op = 3'b000;
        @(negedge clk);
        chk("post_reset_tie", {req0_ready, req1_ready}, 2'b10);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared 8-bit combinational ALU (add, sub, and, or, not; opcodes 000–100, others yield 0). It accepts operation requests over valid/ready handshakes and grants the ALU to one requester at a time (round-robin by default). It drives the ALU operands and opcode from registers, captures the result, and returns it on the winning requester's response channel. It sits between the ALU instance and its client blocks, and is the only driver of the ALU inputs.

## Interface
- `DATA_W`, default 8: operand/result width; must equal the ALU width.

- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0_valid` / `req1_valid` in 1: request present.
- `req0_ready` / `req1_ready` out 1: request accepted this cycle.
- `req0_a` / `req1_a` in DATA_W: operand A.
- `req0_b` / `req1_b` in DATA_W: operand B.
- `req0_op` / `req1_op` in 3: ALU opcode, passed through undecoded.
- `rsp0_valid` / `rsp1_valid` out 1: result available.
- `rsp0_ready` / `rsp1_ready` in 1: requester takes the result.
- `rsp0_result` / `rsp1_result` out DATA_W: result; valid only while the matching rsp valid is high.
- `alu_a` / `alu_b` out DATA_W: registered operands to the ALU.
- `alu_opcode` out 3: registered opcode to the ALU.
- `alu_result` in DATA_W: combinational ALU result.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - If any request valid is high, compute the grant and assert that requester's ready combinationally.
  - On the clock edge, latch that requester's a/b/op into alu_a/alu_b/alu_opcode, record the granted id, and go to EXEC.
- **EXEC** (exactly one cycle): capture alu_result into the result register and go to RESP.
- **RESP**
  - Assert the granted requester's rsp valid, with the result on both rsp result buses (the non-granted bus is don't-care, driven with the same register).
  - On the cycle where the matching rsp ready is high: update last_grant to the granted id and return to IDLE.
- **Arbitration (round-robin)**
  - Only one valid high: grant it.
  - Both valid high: grant the requester not equal to last_grant.
  - last_grant resets to 1, so requester 0 wins the first tie.
- **Handshake rules**
  - Requesters hold valid and payload stable until ready.
  - ready is never asserted outside IDLE; at most one ready is high per cycle.
  - ready does not depend on any rsp ready.
  - A requester may hold a new request valid while awaiting its own response; it is not accepted until IDLE.
- **Arithmetic:** no sign or width handling in this block. Sub wraps modulo 2^DATA_W (0x05−0x0A = 0xFB). Opcodes 101–111 return 0x00.
- alu_a/alu_b/alu_opcode hold their last values outside EXEC.

## Timing
- **Reset values:**
  - req ready, rsp valid and busy: 0.
  - rsp results, alu_a, alu_b: 0x00; alu_opcode: 000.
  - State: IDLE; last_grant: 1.
- **Latency:** accept edge at cycle N, EXEC in cycle N+1, rsp valid high from cycle N+2.
- **Throughput:** with rsp ready held high, a response completes at the N+2 edge and the next accept can occur at N+3, giving one op per 3 cycles.
- **Backpressure:** rsp valid and result hold for as long as the matching rsp ready stays low; no timeout.
- **Reset mid-operation:** asynchronous return to reset values in any state. The in-flight op is dropped and no response is issued.
- The ALU output path is fully registered: one combinational ALU delay within the EXEC cycle.

## Configuration
- `ALU_ARB_FIXED_PRI_EN` defined:
  - Fixed priority; requester 0 wins every tie.
  - last_grant is not implemented; the single-valid behaviour is unchanged.
- Undefined (default): round-robin as specified above.

## Test plan
- Reset, then req0 with a=0x0A, b=0x05, op=000 and rsp0_ready=1 -> req0_ready high in the accept cycle; rsp0_valid 2 cycles later with result 0x0F; rsp1_valid stays 0.
- Both requesters valid continuously (req0: 0x0A−0x05, op 001; req1: ~0x0A, op 100) -> grants alternate 0,1,0,…, with results 0x05 and 0xF5. With `ALU_ARB_FIXED_PRI_EN`, requester 0 is granted every time.
- Hold rsp1_ready low for 5 cycles after rsp1_valid (op 010, a=0xF0, b=0x3C) -> result stays 0x30; busy stays 1; no ready asserted; completes on the first rsp1_ready.
- op=110 with a=0xFF, b=0xFF -> result 0x00; op 000 with the same operands -> result 0xFE (wraps).
- Assert rst_n low during EXEC -> all outputs immediately at reset values; no rsp valid afterwards. Next req0 after reset wins a tie with req1.
- Back-to-back req0 with rsp0_ready tied high -> accepts spaced exactly 3 cycles apart.
